note_player: RTL and testbench

Buffered note playback engine for the electronic organ. It accepts note requests (note, octave, length in beats) over a valid/ready handshake into a 4-entry FIFO. It plays each request as a square wave on the buzzer pin for an exact number of beats, then inserts a silent articulation gap. It sits between the song/keyboard sequencing logic, which is the note writer, and the buzzer pad; this block is the note reader.

---
 rtl/organ_pkg.sv | 67 ++++++
 rtl/note_fifo.sv | 54 +++++
 rtl/note_player.sv | 162 ++++++++++++++++
 tb/tb_note_player.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/organ_pkg.sv
// Shared types and pitch table for the organ note playback path.
// Half-periods are in clk cycles at 100 MHz for the middle octave.
package organ_pkg;

    localparam logic [3:0] NOTE_REST = 4'd0;
    localparam logic [3:0] NOTE_DO   = 4'd1;
    localparam logic [3:0] NOTE_RE   = 4'd2;
    localparam logic [3:0] NOTE_MI   = 4'd3;
    localparam logic [3:0] NOTE_FA   = 4'd4;
    localparam logic [3:0] NOTE_SOL  = 4'd5;
    localparam logic [3:0] NOTE_LA   = 4'd6;
    localparam logic [3:0] NOTE_SI   = 4'd7;

    localparam int HP_W = 20;

    typedef enum logic [1:0] {
        OCT_LOW  = 2'd0,
        OCT_MID  = 2'd1,
        OCT_HIGH = 2'd2,
        OCT_TOP  = 2'd3
    } octave_e;

    localparam logic [HP_W-1:0] MID_HALF_PERIOD [1:7] = '{
        20'd190840, 20'd170068, 20'd151515, 20'd143266,
        20'd127551, 20'd113636, 20'd101215
    };

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_PLAY = 2'd2,
        ST_GAP  = 2'd3
    } state_e;

    typedef struct packed {
        logic [3:0] note;
        octave_e    octave;
        logic [3:0] beats;
    } req_t;

    // Codes 8..15 are treated as rests, same as 0.
    function automatic logic is_tone(input logic [3:0] note);
        return (note != NOTE_REST) && (note[3] == 1'b0);
    endfunction

    function automatic logic [HP_W-1:0] half_period(input logic [3:0] note,
                                                    input octave_e oct,
                                                    input int unsigned shift);
        logic [HP_W-1:0] base;
        logic [HP_W-1:0] hp;
        base = '0;
        if (is_tone(note)) begin
            base = MID_HALF_PERIOD[note[2:0]];
        end
        case (oct)
            OCT_LOW: hp = base << 1;
            OCT_MID: hp = base;
            default: hp = base >> 1;
        endcase
        hp = hp >> shift;
        if (hp == '0) begin
            hp = HP_W'(1);
        end
        return hp;
    endfunction

endpackage

// File: rtl/note_fifo.sv
// Request buffer: synchronous FIFO with flush and occupancy; read data is the head, combinational.
// Push when full and pop when empty are ignored; flush wins over push and pop.
module note_fifo #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       i_push,
    input  logic [WIDTH-1:0]           i_dat,
    input  logic                       i_pop,
    input  logic                       i_flush,
    output logic [WIDTH-1:0]           o_dat,
    output logic [$clog2(DEPTH):0]     o_level,
    output logic                       o_full,
    output logic                       o_empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_level;
    logic             w_push;
    logic             w_pop;

    assign o_full  = (r_level == (AW+1)'(DEPTH));
    assign o_empty = (r_level == '0);
    assign o_level = r_level;
    assign o_dat   = r_mem[r_rd_ptr];
    assign w_push  = i_push && !o_full && !i_flush;
    assign w_pop   = i_pop && !o_empty && !i_flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            r_level <= r_level + {{AW{1'b0}}, w_push} - {{AW{1'b0}}, w_pop};
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_dat;
    end

endmodule

// File: rtl/note_player.sv
// Plays buffered note requests as a square wave for whole beats, then a silent gap.
// Accept to PLAY is 2 cycles; in_ready drops when the FIFO is full or stop is high.
module note_player
    import organ_pkg::*;
#(
    parameter int unsigned BEAT_CYCLES = 12_500_000,
    parameter int unsigned GAP_CYCLES  = 1_000_000,
    parameter int unsigned FIFO_DEPTH  = 4,
    parameter int unsigned TONE_SHIFT  = 0
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            en,
    input  logic                            stop,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [3:0]                      in_note,
    input  logic [1:0]                      in_octave,
    input  logic [3:0]                      in_beats,
    output logic                            buzzer,
    output logic                            playing,
    output logic [3:0]                      cur_note,
    output logic                            beat_pulse,
    output logic [$clog2(FIFO_DEPTH):0]     fifo_level
);
    localparam int BW = $clog2(BEAT_CYCLES + 1);
    localparam int GW = $clog2(GAP_CYCLES + 1);
    localparam logic [BW-1:0] BEAT_LAST = BW'(BEAT_CYCLES - 1);
    localparam logic [GW-1:0] GAP_LAST  = GW'(GAP_CYCLES - 1);

    state_e              r_state;
    req_t                r_req;
    logic [HP_W-1:0]     r_half;
    logic [HP_W-1:0]     r_tone_cnt;
    logic [BW-1:0]       r_beat_cnt;
    logic [GW-1:0]       r_gap_cnt;
    logic [3:0]          r_beats_left;
    logic                r_tone;
    logic                r_playing;
    logic                r_beat_pulse;
    logic [3:0]          r_cur_note;

    req_t                w_in_req;
    req_t                w_head;
    logic [$bits(req_t)-1:0] w_head_dat;
    logic                w_push;
    logic                w_pop;
    logic                w_full;
    logic                w_empty;

    assign w_in_req   = '{note: in_note, octave: octave_e'(in_octave), beats: in_beats};
    assign w_head     = req_t'(w_head_dat);
    assign in_ready   = !w_full && !stop;
    assign w_push     = in_valid && in_ready;
    assign w_pop      = en && !stop && (r_state == ST_IDLE) && !w_empty;

    // Toggle state is kept while frozen so the tone phase resumes with en.
    assign buzzer     = r_tone & en;
    assign playing    = r_playing;
    assign cur_note   = r_cur_note;
    assign beat_pulse = r_beat_pulse;

    note_fifo #(
        .WIDTH($bits(req_t)),
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_dat   (w_in_req),
        .i_pop   (w_pop),
        .i_flush (stop),
        .o_dat   (w_head_dat),
        .o_level (fifo_level),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_req        <= '0;
            r_half       <= '0;
            r_tone_cnt   <= '0;
            r_beat_cnt   <= '0;
            r_gap_cnt    <= '0;
            r_beats_left <= '0;
            r_tone       <= 1'b0;
            r_playing    <= 1'b0;
            r_beat_pulse <= 1'b0;
            r_cur_note   <= '0;
        end else if (stop) begin
            r_state      <= ST_IDLE;
            r_tone_cnt   <= '0;
            r_beat_cnt   <= '0;
            r_gap_cnt    <= '0;
            r_beats_left <= '0;
            r_tone       <= 1'b0;
            r_playing    <= 1'b0;
            r_beat_pulse <= 1'b0;
            r_cur_note   <= '0;
        end else begin
            r_beat_pulse <= 1'b0;
            if (en) begin
                case (r_state)
                    ST_IDLE: begin
                        if (!w_empty) begin
                            r_req   <= w_head;
                            r_state <= ST_LOAD;
                        end
                    end
                    ST_LOAD: begin
                        r_half       <= half_period(r_req.note, r_req.octave, TONE_SHIFT);
                        r_beats_left <= r_req.beats;
                        r_tone_cnt   <= '0;
                        r_beat_cnt   <= '0;
                        r_tone       <= 1'b0;
                        if (r_req.beats == 4'd0) begin
                            r_state <= ST_IDLE;
                        end else begin
                            r_state    <= ST_PLAY;
                            r_playing  <= 1'b1;
                            r_cur_note <= is_tone(r_req.note) ? r_req.note : NOTE_REST;
                        end
                    end
                    ST_PLAY: begin
                        if (r_tone_cnt == r_half - HP_W'(1)) begin
                            r_tone_cnt <= '0;
                            if (r_cur_note != NOTE_REST) r_tone <= ~r_tone;
                        end else begin
                            r_tone_cnt <= r_tone_cnt + HP_W'(1);
                        end
                        if (r_beat_cnt == BEAT_LAST) begin
                            r_beat_cnt   <= '0;
                            r_beat_pulse <= 1'b1;
                            r_beats_left <= r_beats_left - 4'd1;
                            // Last beat: silence takes precedence over a coincident tone toggle.
                            if (r_beats_left == 4'd1) begin
                                r_state    <= ST_GAP;
                                r_tone     <= 1'b0;
                                r_cur_note <= '0;
                                r_gap_cnt  <= '0;
                            end
                        end else begin
                            r_beat_cnt <= r_beat_cnt + BW'(1);
                        end
                    end
                    ST_GAP: begin
                        if (r_gap_cnt == GAP_LAST) begin
                            r_state   <= ST_IDLE;
                            r_playing <= 1'b0;
                        end else begin
                            r_gap_cnt <= r_gap_cnt + GW'(1);
                        end
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_note_player.sv
// Randomised scoreboard bench for note_player with a cycle-accurate behavioural note model.
module tb_note_player;
    localparam int BEAT  = 10;
    localparam int GAP   = 4;
    localparam int DEPTH = 4;
    localparam int SHIFT = 10;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       en = 1'b0;
    logic       stop = 1'b0;
    logic       in_valid = 1'b0;
    logic [3:0] in_note = '0;
    logic [1:0] in_octave = '0;
    logic [3:0] in_beats = '0;
    logic       in_ready;
    logic       buzzer;
    logic       playing;
    logic [3:0] cur_note;
    logic       beat_pulse;
    logic [2:0] fifo_level;

    note_player #(
        .BEAT_CYCLES(BEAT),
        .GAP_CYCLES (GAP),
        .FIFO_DEPTH (DEPTH),
        .TONE_SHIFT (SHIFT)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .stop       (stop),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_note    (in_note),
        .in_octave  (in_octave),
        .in_beats   (in_beats),
        .buzzer     (buzzer),
        .playing    (playing),
        .cur_note   (cur_note),
        .beat_pulse (beat_pulse),
        .fifo_level (fifo_level)
    );

    always #5 clk = ~clk;

    typedef struct {
        int note_n;
        int hp;
        int beats;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   failures = 0;
    int   act = 0;
    bit   act_inc = 0;
    bit   in_seg = 0;
    bit   prev_playing = 0;
    exp_t cur;
    int   t0 = 0;
    bit   rand_en = 0;
    bit   done = 0;
    int   mid_hp [8] = '{0, 190840, 170068, 151515, 143266, 127551, 113636, 101215};

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    function automatic int model_hp(input int note, input int oct);
        int hp;
        hp = mid_hp[note];
        if (oct == 0) hp = hp * 2;
        else if (oct >= 2) hp = hp / 2;
        hp = hp / (1 << SHIFT);
        if (hp < 1) hp = 1;
        return hp;
    endfunction

    // Time in enabled clock edges: the design only advances on these.
    always @(posedge clk) begin
        act_inc = rst_n && en;
        if (act_inc) act++;
    end

    // Monitor: every note segment runs from playing rising to playing falling.
    always @(negedge clk) begin
        int rel, len, e_note, e_buz, e_pulse, e_play;
        if (!rst_n) begin
            in_seg = 0;
            prev_playing = 0;
            chk("rst_playing", playing, 0);
            chk("rst_buzzer", buzzer, 0);
            chk("rst_cur_note", cur_note, 0);
            chk("rst_beat_pulse", beat_pulse, 0);
            chk("rst_fifo_level", fifo_level, 0);
            chk("rst_in_ready", in_ready, 1);
        end else begin
            if (!in_seg && playing && !prev_playing) begin
                if (sb.size() == 0) begin
                    chk("unexpected_play", playing, 0);
                end else begin
                    cur = sb.pop_front();
                    in_seg = 1;
                    t0 = act;
                end
            end
            if (in_seg) begin
                rel     = act - t0;
                len     = cur.beats * BEAT;
                e_note  = (rel < len) ? cur.note_n : 0;
                e_buz   = (en && cur.note_n != 0 && rel < len && ((rel / cur.hp) % 2 == 1)) ? 1 : 0;
                e_pulse = (act_inc && rel > 0 && rel <= len && (rel % BEAT) == 0) ? 1 : 0;
                e_play  = (rel < len + GAP) ? 1 : 0;
                chk("seg_playing", playing, e_play);
                chk("seg_cur_note", cur_note, e_note);
                chk("seg_buzzer", buzzer, e_buz);
                chk("seg_beat_pulse", beat_pulse, e_pulse);
                if (e_play == 0) in_seg = 0;
            end else begin
                chk("idle_playing", playing, 0);
                chk("idle_buzzer", buzzer, 0);
                chk("idle_cur_note", cur_note, 0);
                chk("idle_beat_pulse", beat_pulse, 0);
            end
            if (stop) in_seg = 0;
            prev_playing = playing;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        if (rand_en) en = ($urandom_range(0, 7) != 0);
    endtask

    task automatic push_req(input int note, input int oct, input int beats, output int lvl);
        int   n;
        bit   acc;
        exp_t e;
        n = 0;
        acc = 0;
        lvl = 0;
        in_note   = 4'(note);
        in_octave = 2'(oct);
        in_beats  = 4'(beats);
        in_valid  = 1'b1;
        while (!acc && n < 3000) begin
            @(negedge clk);
            if (in_ready) begin
                acc = 1;
                lvl = int'(fifo_level);
                if (beats != 0) begin
                    e.note_n = (note >= 1 && note <= 7) ? note : 0;
                    e.hp     = (e.note_n != 0) ? model_hp(note, oct) : 1;
                    e.beats  = beats;
                    sb.push_back(e);
                end
            end
            step();
            n++;
        end
        in_valid = 1'b0;
        if (!acc) chk("push_accept_timeout", int'(in_ready), 1);
    endtask

    task automatic wait_play(input int bound);
        int n;
        n = 0;
        while (!playing && n < bound) begin
            step();
            n++;
        end
        chk("wait_play", playing, 1);
    endtask

    task automatic wait_idle(input int bound);
        int n;
        bit idle;
        n = 0;
        idle = 0;
        while (!idle && n < bound) begin
            idle = (sb.size() == 0) && !in_seg && !playing && (fifo_level == 0);
            if (!idle) step();
            n++;
        end
        chk("wait_idle", int'(idle), 1);
        repeat (3) step();
    endtask

    initial begin
        #500000;
        if (!done) begin
            failures++;
            $display("FAIL watchdog: got no completion, required completion by %0t", $time);
            $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
            $finish;
        end
    end

    initial begin
        int lvl;
        int n;
        #1 rst_n = 1'b0;
        en = 1'b1;
        step();
        step();
        chk("reset_in_ready", in_ready, 1);
        chk("reset_fifo_level", fifo_level, 0);
        chk("reset_playing", playing, 0);
        chk("reset_buzzer", buzzer, 0);
        rst_n = 1'b1;
        step();

        // First request into an empty, idle engine: LA mid, 2 beats.
        push_req(6, 1, 2, lvl);
        chk("lat_level_E", fifo_level, 1);
        chk("lat_playing_E", playing, 0);
        step();
        chk("lat_playing_E1", playing, 0);
        chk("lat_level_E1", fifo_level, 0);
        step();
        chk("lat_playing_E2", playing, 1);
        chk("lat_cur_note_E2", cur_note, 6);
        wait_idle(200);

        // Burst of five behind a long note: the fifth waits for the first pop.
        push_req(5, 1, 15, lvl);
        wait_play(20);
        for (int i = 0; i < 4; i++)
            push_req($urandom_range(1, 7), $urandom_range(0, 3), $urandom_range(1, 3), lvl);
        chk("burst_full_level", fifo_level, 4);
        chk("burst_full_ready", in_ready, 0);
        push_req(2, 2, 1, lvl);
        chk("burst_level_after_pop", lvl, 3);
        wait_idle(2000);

        // Rests (code 0 and an out-of-range code) and a zero-beat skip between notes.
        push_req(0, 1, 1, lvl);
        push_req(12, 3, 2, lvl);
        wait_idle(200);
        push_req(1, 0, 0, lvl);
        for (int i = 0; i < 12; i++) begin
            step();
            chk("skip_playing", playing, 0);
        end
        push_req(3, 1, 1, lvl);
        push_req(1, 0, 0, lvl);
        push_req(4, 2, 1, lvl);
        wait_idle(300);

        // Freeze for 7 cycles mid-note while the buzzer is high.
        push_req(7, 2, 8, lvl);
        wait_play(20);
        repeat (60) step();
        en = 1'b0;
        for (int i = 0; i < 7; i++) begin
            step();
            chk("hold_buzzer", buzzer, 0);
        end
        en = 1'b1;
        wait_idle(300);

        // Flush mid-note with three entries queued and a request on the input.
        push_req(3, 2, 10, lvl);
        wait_play(20);
        push_req(1, 1, 2, lvl);
        push_req(2, 1, 2, lvl);
        push_req(3, 1, 2, lvl);
        chk("stop_pre_level", fifo_level, 3);
        repeat (20) step();
        in_note = 4'd5;
        in_octave = 2'd1;
        in_beats = 4'd3;
        in_valid = 1'b1;
        stop = 1'b1;
        sb.delete();
        @(negedge clk);
        chk("stop_in_ready", in_ready, 0);
        step();
        stop = 1'b0;
        in_valid = 1'b0;
        chk("stop_fifo_level", fifo_level, 0);
        chk("stop_playing", playing, 0);
        chk("stop_buzzer", buzzer, 0);
        chk("stop_cur_note", cur_note, 0);
        repeat (20) step();
        chk("stop_no_replay", playing, 0);

        // Asynchronous reset during the gap with another note queued.
        push_req(2, 0, 1, lvl);
        push_req(4, 1, 2, lvl);
        n = 0;
        while (!beat_pulse && n < 200) begin
            step();
            n++;
        end
        chk("gap_reached", beat_pulse, 1);
        chk("gap_playing", playing, 1);
        step();
        rst_n = 1'b0;
        sb.delete();
        #1;
        chk("arst_playing", playing, 0);
        chk("arst_fifo_level", fifo_level, 0);
        chk("arst_in_ready", in_ready, 1);
        chk("arst_buzzer", buzzer, 0);
        step();
        step();
        rst_n = 1'b1;
        repeat (20) step();
        chk("arst_no_replay", playing, 0);

        // Random requests with random enable drops.
        rand_en = 1;
        for (int i = 0; i < 30; i++) begin
            push_req($urandom_range(0, 15), $urandom_range(0, 3), $urandom_range(0, 12), lvl);
            repeat ($urandom_range(0, 30)) step();
        end
        rand_en = 0;
        en = 1'b1;
        wait_idle(8000);
        chk("scoreboard_empty", sb.size(), 0);

        done = 1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
